mem_burst_ctrl: RTL and testbench

Memory-side stage that sits directly downstream of the direct-mapped write-through cache. It services the cache's 4-word burst protocol (mem_req/mem_gnt, fixed-timing data) on one side. On the other side it drives a per-word, in-order command/response memory interface that can stall. The block decouples the two with a 4-word line buffer, so the cache always sees its fixed post-grant data timing regardless of backend stalls.

---
 rtl/mem_burst_ctrl.sv | 87 ++++++++
 tb/tb_mem_burst_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_burst_ctrl.sv
// mem_burst_ctrl: adapts the cache's fixed-timing 4-word burst to a stallable per-word backend via a line buffer
module mem_burst_ctrl #(
  parameter int LOG2BYTEWIDTH = 3,
  parameter int ADDRWIDTH = 20,
  localparam int DATAWIDTH = (1 << LOG2BYTEWIDTH) * 8,
  localparam int LOG2LINESIZE = 2 + LOG2BYTEWIDTH
) (
  input  logic                 clk,
  input  logic                 reset_l,
  input  logic                 mem_req,
  output logic                 mem_gnt,
  input  logic                 mem_write,
  input  logic [ADDRWIDTH-1:0] mem_addr,
  input  logic [DATAWIDTH-1:0] mem_wr_data,
  output logic [DATAWIDTH-1:0] mem_rd_data,
  output logic                 ext_cmd_valid,
  input  logic                 ext_cmd_ready,
  output logic                 ext_cmd_write,
  output logic [ADDRWIDTH-1:0] ext_cmd_addr,
  output logic [DATAWIDTH-1:0] ext_wr_data,
  input  logic                 ext_rd_valid,
  input  logic [DATAWIDTH-1:0] ext_rd_data
);
  localparam logic [ADDRWIDTH-1:0] LINE_MASK = ~ADDRWIDTH'((1 << LOG2LINESIZE) - 1);
  typedef enum logic [2:0] {IDLE, WR_GNT, WR_CAP, WR_ISSUE, RD_ISSUE, RD_WAIT, RD_GNT, RD_STREAM} state_t;
  state_t state, nxt;
  logic [ADDRWIDTH-1:0] base;
  logic [1:0] k;
  logic [2:0] rsp_cnt;
  logic [DATAWIDTH-1:0] line [4];
  logic accept, rsp_take;
  assign accept = ext_cmd_valid && ext_cmd_ready;
  // rsp_cnt[2] set means all four responses are in; extras are dropped
  assign rsp_take = ext_rd_valid && (state == RD_ISSUE || state == RD_WAIT) && !rsp_cnt[2];
  always_ff @(posedge clk)
    state <= !reset_l ? IDLE : nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:      nxt = !mem_req ? IDLE : mem_write ? WR_GNT : RD_ISSUE;
      WR_GNT:    nxt = WR_CAP;
      WR_CAP:    nxt = k == 2'd3 ? WR_ISSUE : WR_CAP;
      WR_ISSUE:  nxt = accept && k == 2'd3 ? IDLE : WR_ISSUE;
      RD_ISSUE:  nxt = accept && k == 2'd3 ? RD_WAIT : RD_ISSUE;
      RD_WAIT:   nxt = rsp_cnt[2] || (rsp_take && rsp_cnt == 3'd3) ? RD_GNT : RD_WAIT;
      RD_GNT:    nxt = RD_STREAM;
      RD_STREAM: nxt = k == 2'd3 ? IDLE : RD_STREAM;
      default:   nxt = IDLE;
    endcase
  end
  always_comb begin
    ext_cmd_valid = state == WR_ISSUE || state == RD_ISSUE;
    ext_cmd_write = state == WR_ISSUE;
    ext_cmd_addr = base + (ADDRWIDTH'(k) << LOG2BYTEWIDTH);
    ext_wr_data = line[k];
  end
  always_ff @(posedge clk) begin
    if (!reset_l) begin
      base <= '0;
      k <= '0;
      rsp_cnt <= '0;
      line <= '{default: '0};
      mem_gnt <= 1'b0;
      mem_rd_data <= '0;
    end else begin
      mem_gnt <= nxt == WR_GNT || nxt == RD_GNT;
      if (state == IDLE) begin
        base <= mem_addr & LINE_MASK;
        k <= '0;
        rsp_cnt <= '0;
      end
      if (state == WR_GNT || state == WR_CAP) begin
        line[k] <= mem_wr_data;
        k <= k + 2'd1;
      end
      if (accept) k <= k + 2'd1;
      if (rsp_take) begin
        line[rsp_cnt[1:0]] <= ext_rd_data;
        rsp_cnt <= rsp_cnt + 3'd1;
      end
      if (state == RD_GNT || state == RD_STREAM) begin
        mem_rd_data <= line[k];
        k <= k + 2'd1;
      end
    end
  end
endmodule

// File: tb/tb_mem_burst_ctrl.sv
// tb_mem_burst_ctrl: randomized scoreboard bench against a word-addressed memory reference model
module tb_mem_burst_ctrl;
  logic clk = 0, reset_l, mem_req, mem_gnt, mem_write;
  logic [19:0] mem_addr, ext_cmd_addr;
  logic [63:0] mem_wr_data, mem_rd_data, ext_wr_data, ext_rd_data;
  logic ext_cmd_valid, ext_cmd_ready, ext_cmd_write, ext_rd_valid;

  mem_burst_ctrl dut (
    .clk(clk), .reset_l(reset_l), .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data),
    .ext_cmd_valid(ext_cmd_valid), .ext_cmd_ready(ext_cmd_ready), .ext_cmd_write(ext_cmd_write),
    .ext_cmd_addr(ext_cmd_addr), .ext_wr_data(ext_wr_data), .ext_rd_valid(ext_rd_valid),
    .ext_rd_data(ext_rd_data)
  );

  typedef struct { bit wr; logic [19:0] addr; logic [63:0] d; int cyc; } cmd_t;
  typedef struct { int due; logic [63:0] d; } rsp_t;
  typedef struct { bit wr; int cyc; } gnt_t;
  cmd_t exp_cmd[$];
  logic [63:0] exp_rd[$];
  gnt_t exp_gnt[$];
  rsp_t resp[$];
  bit pat[$];
  logic [63:0] ram [1024];
  logic [63:0] ref_mem [1024];
  int n_cmp = 0, n_bad = 0, cyc = 0;
  int rmode = 0, lat = 1, spacing = 1, rsp_n = 0, last4 = 0;
  bit rd_active = 0;

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", n, cyc, act, exp);
    end
  endtask

  function automatic int widx(input logic [19:0] a, input int k);
    return ((int'(a) / 32) * 4 + k) % 1024;
  endfunction
  function automatic logic [19:0] waddr(input logic [19:0] a, input int k);
    return 20'((int'(a) / 32) * 32 + 8 * k);
  endfunction

  // backend: stallable command port, in-order read responses from its own RAM
  initial begin
    bit hold = 0;
    logic [19:0] h_addr;
    logic [63:0] h_data;
    logic h_wr;
    int last_rsp = -100;
    cmd_t e;
    ext_cmd_ready = 0; ext_rd_valid = 0; ext_rd_data = 0;
    forever begin
      @(negedge clk);
      if (!reset_l) begin
        resp.delete(); hold = 0; ext_cmd_ready = 0; ext_rd_valid = 0;
        continue;
      end
      if (hold) begin
        chk("hold_valid", ext_cmd_valid, 1);
        chk("hold_addr", ext_cmd_addr, h_addr);
        chk("hold_write", ext_cmd_write, h_wr);
        if (h_wr) chk("hold_data", ext_wr_data, h_data);
      end
      if (ext_cmd_valid && pat.size() > 0) ext_cmd_ready = pat.pop_front();
      else ext_cmd_ready = rmode == 0 ? 1'b1 : rmode == 1 ? 1'($urandom_range(0, 1)) : 1'b0;
      hold = ext_cmd_valid && !ext_cmd_ready;
      h_addr = ext_cmd_addr; h_data = ext_wr_data; h_wr = ext_cmd_write;
      if (ext_cmd_valid && ext_cmd_ready) begin
        if (exp_cmd.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL cmd_unexpected at cycle %0d: got command to %h, expected none", cyc, ext_cmd_addr);
        end else begin
          e = exp_cmd.pop_front();
          chk("cmd_write", ext_cmd_write, e.wr);
          chk("cmd_addr", ext_cmd_addr, e.addr);
          if (e.wr) chk("cmd_data", ext_wr_data, e.d);
          if (e.cyc >= 0) chk("cmd_cycle", 64'(cyc), 64'(e.cyc));
        end
        if (ext_cmd_write) ram[ext_cmd_addr[12:3]] = ext_wr_data;
        else resp.push_back('{cyc + lat, ram[ext_cmd_addr[12:3]]});
      end
      if (resp.size() > 0 && resp[0].due <= cyc && cyc >= last_rsp + spacing) begin
        ext_rd_valid = 1; ext_rd_data = resp[0].d; void'(resp.pop_front());
        last_rsp = cyc; rsp_n++;
        if (rsp_n == 4) last4 = cyc;
      end else begin
        ext_rd_valid = !rd_active && $urandom_range(0, 3) == 0;
        ext_rd_data = {$urandom, $urandom};
      end
    end
  end

  // monitor: grant timing and the read stream on the cache side
  initial begin
    int sl = 0;
    logic [63:0] last_rd = 0, e;
    gnt_t g;
    forever begin
      @(negedge clk);
      if (!reset_l) begin sl = 0; last_rd = 0; continue; end
      if (mem_gnt) begin
        if (exp_gnt.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL gnt_unexpected at cycle %0d: got mem_gnt=1, expected 0", cyc);
        end else begin
          g = exp_gnt.pop_front();
          if (g.wr) chk("wr_gnt_cycle", 64'(cyc), 64'(g.cyc));
          else begin chk("rd_gnt_cycle", 64'(cyc), 64'(last4 + 1)); sl = 4; end
        end
      end else if (sl > 0) begin
        e = exp_rd.size() > 0 ? exp_rd.pop_front() : 64'hx;
        chk("rd_data", mem_rd_data, e);
        last_rd = e; sl--;
      end else chk("rd_hold", mem_rd_data, last_rd);
    end
  end

  task automatic wait_gnt();
    int t = 0;
    do begin @(negedge clk); t++; end while (!mem_gnt && t < 300);
    chk("gnt_seen", mem_gnt, 1);
  endtask

  task automatic do_write(input logic [19:0] a, input logic [63:0] w [4], input int n, input bit timed);
    int c0 = cyc, t = 0;
    for (int k = 0; k < 4; k++) exp_cmd.push_back('{1, waddr(a, k), w[k], timed ? c0 + 5 + k : -1});
    for (int k = 0; k < n; k++) ref_mem[widx(a, k)] = w[k];
    exp_gnt.push_back('{1, c0 + 1});
    mem_req = 1; mem_write = 1; mem_addr = a; mem_wr_data = w[0];
    wait_gnt();
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      mem_req = 0; mem_addr = 20'($urandom); mem_wr_data = w[k];
    end
    @(negedge clk);
    mem_wr_data = {$urandom, $urandom};
    while (exp_cmd.size() > 4 - n && t < 300) begin @(negedge clk); t++; end
    chk("wr_accepts_left", 64'(exp_cmd.size()), 64'(4 - n));
    if (n == 4) @(negedge clk);
  endtask

  task automatic do_read(input logic [19:0] a, input bit timed);
    int c0 = cyc;
    rd_active = 1; rsp_n = 0;
    for (int k = 0; k < 4; k++) begin
      exp_cmd.push_back('{0, waddr(a, k), 0, timed ? c0 + 1 + k : -1});
      exp_rd.push_back(ref_mem[widx(a, k)]);
    end
    exp_gnt.push_back('{0, 0});
    mem_req = 1; mem_write = 0; mem_addr = a;
    wait_gnt();
    mem_req = 0; mem_write = 1'($urandom); mem_addr = 20'($urandom);
    repeat (5) @(negedge clk);
    rd_active = 0;
  endtask

  initial begin
    logic [63:0] w [4];
    logic [19:0] a;
    reset_l = 0; mem_req = 0; mem_write = 0; mem_addr = 0; mem_wr_data = 0;
    for (int i = 0; i < 1024; i++) begin ram[i] = {$urandom, $urandom}; ref_mem[i] = ram[i]; end
    repeat (3) @(negedge clk);
    chk("rst_gnt", mem_gnt, 0);
    chk("rst_rd_data", mem_rd_data, 0);
    chk("rst_cmd_valid", ext_cmd_valid, 0);
    chk("rst_cmd_write", ext_cmd_write, 0);
    chk("rst_cmd_addr", ext_cmd_addr, 0);
    chk("rst_wr_data", ext_wr_data, 0);
    @(posedge clk); #2 reset_l = 1;
    @(negedge clk);
    // fixed-timing write and read
    for (int k = 0; k < 4; k++) w[k] = 64'hA0 + 64'(k);
    do_write(20'h01238, w, 4, 1);
    for (int k = 0; k < 4; k++) begin ram[widx(20'h00040, k)] = 64'hB0 + 64'(k); ref_mem[widx(20'h00040, k)] = 64'hB0 + 64'(k); end
    do_read(20'h00040, 1);
    // stalled write
    pat = '{1, 0, 0, 1, 0, 1, 1};
    for (int k = 0; k < 4; k++) w[k] = {$urandom, $urandom};
    do_write(20'h00A10, w, 4, 0);
    // spaced responses, first arriving before the second command is accepted
    pat = '{1, 0, 0, 0, 1, 1, 1}; spacing = 3;
    do_read(20'h01238, 0);
    spacing = 1;
    // write then read of the same line
    for (int k = 0; k < 4; k++) w[k] = 64'hC0 + 64'(k);
    do_write(20'h00100, w, 4, 0);
    do_read(20'h00108, 0);
    // reset after two accepted write words
    rmode = 2; pat = '{1, 1};
    for (int k = 0; k < 4; k++) w[k] = {$urandom, $urandom};
    do_write(20'h00300, w, 2, 0);
    @(posedge clk); #2 reset_l = 0;
    @(posedge clk); #2 reset_l = 1;
    @(negedge clk);
    chk("mid_rst_cmd_valid", ext_cmd_valid, 0);
    chk("mid_rst_gnt", mem_gnt, 0);
    chk("mid_rst_rd_data", mem_rd_data, 0);
    chk("mid_rst_dropped_cmds", 64'(exp_cmd.size()), 2);
    exp_cmd.delete(); rmode = 0;
    do_read(20'h00300, 0);
    // randomized bursts
    for (int i = 0; i < 40; i++) begin
      rmode = $urandom_range(0, 1); lat = $urandom_range(1, 4); spacing = $urandom_range(1, 3);
      a = 20'($urandom_range(0, 1023)) | (20'($urandom) & 20'hFE000);
      if ($urandom_range(0, 1) == 1) begin
        for (int k = 0; k < 4; k++) w[k] = {$urandom, $urandom};
        do_write(a, w, 4, 0);
      end else do_read(a, 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    repeat (3) @(negedge clk);
    chk("end_cmd_queue", 64'(exp_cmd.size()), 0);
    chk("end_rd_queue", 64'(exp_rd.size()), 0);
    chk("end_gnt_queue", 64'(exp_gnt.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
